// File: rtl/calc2_pkg.sv
// Shared Calc2 encodings, widths, FSM state and request/response payloads.
package calc2_pkg;

  localparam int unsigned TAG_W  = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CMD_W  = 4;
  localparam int unsigned RSP_W  = 2;

  localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

  localparam logic [RSP_W-1:0] RSP_NONE = 2'd0;
  localparam logic [RSP_W-1:0] RSP_OK   = 2'd1;
  localparam logic [RSP_W-1:0] RSP_ERR  = 2'd2;
  localparam logic [RSP_W-1:0] RSP_INT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_DATA2 = 2'd2
  } state_t;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } req_beat_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [RSP_W-1:0]  resp;
    logic [DATA_W-1:0] data;
  } rsp_t;

endpackage

// File: rtl/calc2_tag_pool.sv
// Outstanding-tag bookkeeping: busy bitmap, lowest-free pick, per-tag timeouts.
module calc2_tag_pool
  import calc2_pkg::*;
#(
  parameter int unsigned NUM_TAGS = 4,
  parameter int unsigned TIMEOUT  = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alloc,
  input  logic                rsp_hit,
  input  logic [TAG_W-1:0]    rsp_tag,
  output logic [NUM_TAGS-1:0] busy,
  output logic [TAG_W-1:0]    free_tag,
  output logic                any_free,
  output logic                stray,
  output logic                timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0]    cnt [NUM_TAGS];
  logic [NUM_TAGS-1:0] rsp_sel;
  logic [NUM_TAGS-1:0] set;
  logic [NUM_TAGS-1:0] clr;
  logic [NUM_TAGS-1:0] expire;

  // Descending scan so the lowest free index is the one that sticks.
  always_comb begin
    free_tag = '0;
    any_free = 1'b0;
    for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_tag = TAG_W'(i);
        any_free = 1'b1;
      end
    end
  end

  // A response retires its tag even in the cycle the timeout would fire.
  always_comb begin
    rsp_sel = '0;
    set     = '0;
    clr     = '0;
    expire  = '0;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      rsp_sel[i] = rsp_hit & (rsp_tag == TAG_W'(i));
      clr[i]     = rsp_sel[i] & busy[i];
      expire[i]  = busy[i] & ~rsp_sel[i] & (cnt[i] == CNT_W'(TIMEOUT - 1));
      set[i]     = alloc & (free_tag == TAG_W'(i));
    end
  end

  assign stray   = rsp_hit & ~(|clr);
  assign timeout = |expire;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
      for (int unsigned i = 0; i < NUM_TAGS; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
        busy[i] <= set[i] | (busy[i] & ~clr[i] & ~expire[i]);
        if (set[i] | clr[i] | expire[i] | ~busy[i]) cnt[i] <= '0;
        else                                         cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/calc2_req_driver.sv
// Calc2 port driver: accepts whole ops, serialises them onto the two-cycle request pins, forwards responses.
module calc2_req_driver
  import calc2_pkg::*;
#(
  parameter int unsigned NUM_TAGS = 4,
  parameter int unsigned TIMEOUT  = 256
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [CMD_W-1:0]  op_cmd,
  input  logic [DATA_W-1:0] op_data1,
  input  logic [DATA_W-1:0] op_data2,
  output logic [TAG_W-1:0]  op_tag,
  output logic [CMD_W-1:0]  req_cmd_in,
  output logic [TAG_W-1:0]  req_tag_in,
  output logic [DATA_W-1:0] req_data_in,
  input  logic [RSP_W-1:0]  out_response,
  input  logic [TAG_W-1:0]  out_tag,
  input  logic [DATA_W-1:0] out_data,
  output logic              rsp_valid,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [RSP_W-1:0]  rsp_resp,
  output logic [DATA_W-1:0] rsp_data,
  output logic [3:0]        tags_busy,
  output logic              stray_rsp_err,
  output logic              timeout_err
);

  state_t              state;
  state_t              state_nx;
  req_beat_t           req_q;
  req_beat_t           req_d;
  rsp_t                rsp_q;
  logic [DATA_W-1:0]   data2_q;
  logic [NUM_TAGS-1:0] busy;
  logic [TAG_W-1:0]    free_tag;
  logic                any_free;
  logic                alloc;
  logic                rsp_hit;
  logic                stray;
  logic                tmo;

  assign op_ready = (state == ST_IDLE) & any_free & ~reset;
  assign op_tag   = free_tag;
  // A NOP handshake is consumed without touching the pool or the pins.
  assign alloc    = op_valid & op_ready & (op_cmd != CMD_NOP);
  assign rsp_hit  = out_response != RSP_NONE;

  calc2_tag_pool #(
    .NUM_TAGS (NUM_TAGS),
    .TIMEOUT  (TIMEOUT)
  ) u_pool (
    .clk      (c_clk),
    .reset    (reset),
    .alloc    (alloc),
    .rsp_hit  (rsp_hit),
    .rsp_tag  (out_tag),
    .busy     (busy),
    .free_tag (free_tag),
    .any_free (any_free),
    .stray    (stray),
    .timeout  (tmo)
  );

  always_ff @(posedge c_clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (alloc) state_nx = ST_CMD;
      ST_CMD:   state_nx = ST_DATA2;
      ST_DATA2: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Next value of the request pins: first beat on accept, second beat out of CMD.
  always_comb begin
    req_d = '0;
    if (alloc) begin
      req_d.cmd  = op_cmd;
      req_d.tag  = free_tag;
      req_d.data = op_data1;
    end else if (state == ST_CMD) begin
      req_d.data = data2_q;
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      req_q         <= '0;
      data2_q       <= '0;
      rsp_q         <= '0;
      rsp_valid     <= 1'b0;
      stray_rsp_err <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      req_q     <= req_d;
      rsp_valid <= rsp_hit;
      if (alloc)   data2_q <= op_data2;
      if (rsp_hit) rsp_q   <= '{tag: out_tag, resp: out_response, data: out_data};
      stray_rsp_err <= stray_rsp_err | stray;
      timeout_err   <= timeout_err | tmo;
    end
  end

  assign req_cmd_in  = req_q.cmd;
  assign req_tag_in  = req_q.tag;
  assign req_data_in = req_q.data;
  assign rsp_tag     = rsp_q.tag;
  assign rsp_resp    = rsp_q.resp;
  assign rsp_data    = rsp_q.data;
  assign tags_busy   = 4'(busy);

endmodule

// File: tb/tb_calc2_req_driver.sv
// Bench for calc2_req_driver: vector table, directed corner sequences and random traffic vs. a tag/age model.
module tb_calc2_req_driver;

  localparam int unsigned TMO = 16;

  logic        c_clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_cmd;
  logic [31:0] op_data1;
  logic [31:0] op_data2;
  logic [1:0]  op_tag;
  logic [3:0]  req_cmd_in;
  logic [1:0]  req_tag_in;
  logic [31:0] req_data_in;
  logic [1:0]  out_response;
  logic [1:0]  out_tag;
  logic [31:0] out_data;
  logic        rsp_valid;
  logic [1:0]  rsp_tag;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_data;
  logic [3:0]  tags_busy;
  logic        stray_rsp_err;
  logic        timeout_err;

  calc2_req_driver #(.NUM_TAGS(4), .TIMEOUT(TMO)) dut (
    .c_clk(c_clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_cmd(op_cmd), .op_data1(op_data1), .op_data2(op_data2), .op_tag(op_tag),
    .req_cmd_in(req_cmd_in), .req_tag_in(req_tag_in), .req_data_in(req_data_in),
    .out_response(out_response), .out_tag(out_tag), .out_data(out_data),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_resp(rsp_resp), .rsp_data(rsp_data),
    .tags_busy(tags_busy), .stray_rsp_err(stray_rsp_err), .timeout_err(timeout_err)
  );

  always #5 c_clk = ~c_clk;

  typedef struct packed {
    logic        rst;
    logic        valid;
    logic [3:0]  cmd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [1:0]  resp;
    logic [1:0]  rtag;
    logic [31:0] rdata;
  } stim_t;

  typedef struct packed {
    stim_t       s;
    logic [3:0]  e_cmd;
    logic [1:0]  e_tag;
    logic [31:0] e_data;
    logic [3:0]  e_busy;
    logic        e_rv;
    logic [31:0] e_rdata;
  } vec_t;

  typedef struct packed {
    logic [3:0]  c;
    logic [1:0]  t;
    logic [31:0] d;
  } beat_t;

  int checks = 0;
  int errors = 0;

  // Reference model: beat queue for the pins, busy bits with ages, absolute cycle pacing.
  beat_t       q[$];
  logic [3:0]  m_busy;
  int          m_age [4];
  int          cyc;
  int          next_ok;
  beat_t       e_pin;
  logic        e_rv;
  logic [1:0]  e_rtag;
  logic [1:0]  e_rresp;
  logic [31:0] e_rdata;
  logic        e_stray;
  logic        e_tmo;
  logic        last_ready;
  logic [1:0]  last_tag;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic stim_t mk(input logic rst, input logic v, input logic [3:0] c,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input logic [1:0] r, input logic [1:0] t, input logic [31:0] rd);
    stim_t s;
    s = '{rst: rst, valid: v, cmd: c, d1: d1, d2: d2, resp: r, rtag: t, rdata: rd};
    return s;
  endfunction

  function automatic int lowest_free(input logic [3:0] b);
    for (int i = 0; i < 4; i++) if (!b[i]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    q.delete();
    m_busy  = 4'b0;
    for (int i = 0; i < 4; i++) m_age[i] = 0;
    e_pin   = '0;
    e_rv    = 1'b0;
    e_rtag  = 2'b0;
    e_rresp = 2'b0;
    e_rdata = 32'b0;
    e_stray = 1'b0;
    e_tmo   = 1'b0;
    next_ok = cyc + 1;
  endtask

  // One clock: check registered outputs, drive inputs, check comb outputs, advance model, clock.
  task automatic step(input stim_t s);
    int  lf;
    logic exp_ready;
    chk("req_cmd", 32'(req_cmd_in), 32'(e_pin.c));
    chk("req_tag", 32'(req_tag_in), 32'(e_pin.t));
    chk("req_data", req_data_in, e_pin.d);
    chk("tags_busy", 32'(tags_busy), 32'(m_busy));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    chk("stray_err", 32'(stray_rsp_err), 32'(e_stray));
    chk("timeout_err", 32'(timeout_err), 32'(e_tmo));
    if (e_rv) begin
      chk("rsp_tag", 32'(rsp_tag), 32'(e_rtag));
      chk("rsp_resp", 32'(rsp_resp), 32'(e_rresp));
      chk("rsp_data", rsp_data, e_rdata);
    end
    reset = s.rst; op_valid = s.valid; op_cmd = s.cmd; op_data1 = s.d1; op_data2 = s.d2;
    out_response = s.resp; out_tag = s.rtag; out_data = s.rdata;
    #1;
    lf = lowest_free(m_busy);
    exp_ready = !s.rst && (cyc >= next_ok) && (lf >= 0);
    chk("op_ready", 32'(op_ready), 32'(exp_ready));
    last_ready = op_ready;
    last_tag   = op_tag;
    if (exp_ready) chk("op_tag", 32'(op_tag), 32'(lf));
    if (s.rst) begin
      model_clear();
    end else begin
      e_rv = s.resp != 2'd0;
      if (e_rv) begin
        e_rtag = s.rtag; e_rresp = s.resp; e_rdata = s.rdata;
        if (m_busy[s.rtag]) m_busy[s.rtag] = 1'b0;
        else                e_stray = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        if (m_busy[i]) begin
          m_age[i]++;
          if (m_age[i] >= int'(TMO)) begin
            m_busy[i] = 1'b0;
            e_tmo = 1'b1;
          end
        end
      end
      if (exp_ready && s.valid && s.cmd != 4'd0) begin
        m_busy[lf] = 1'b1;
        m_age[lf]  = 0;
        q.push_back('{c: s.cmd, t: 2'(lf), d: s.d1});
        q.push_back('{c: 4'd0, t: 2'd0, d: s.d2});
        next_ok = cyc + 3;
      end
      e_pin = (q.size() > 0) ? q.pop_front() : '0;
    end
    cyc++;
    @(posedge c_clk);
    #1;
  endtask

  stim_t idle_s;
  stim_t rst_s;
  vec_t  tbl [9];

  initial begin
    idle_s = mk(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0);
    rst_s  = mk(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0);
    tbl[0] = '{mk(1'b0, 1'b1, 4'h1, 32'h5, 32'h3, 2'd0, 2'd0, 32'h0),         4'h1, 2'd0, 32'h5,  4'b0001, 1'b0, 32'h0};
    tbl[1] = '{idle_s,                                                         4'h0, 2'd0, 32'h3,  4'b0001, 1'b0, 32'h0};
    tbl[2] = '{idle_s,                                                         4'h0, 2'd0, 32'h0,  4'b0001, 1'b0, 32'h0};
    tbl[3] = '{mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'd1, 2'd0, 32'h8),         4'h0, 2'd0, 32'h0,  4'b0000, 1'b1, 32'h8};
    tbl[4] = '{mk(1'b0, 1'b1, 4'h0, 32'hAA, 32'hBB, 2'd0, 2'd0, 32'h0),       4'h0, 2'd0, 32'h0,  4'b0000, 1'b0, 32'h0};
    tbl[5] = '{mk(1'b0, 1'b1, 4'hF, 32'h11, 32'h22, 2'd0, 2'd0, 32'h0),       4'hF, 2'd0, 32'h11, 4'b0001, 1'b0, 32'h0};
    tbl[6] = '{idle_s,                                                         4'h0, 2'd0, 32'h22, 4'b0001, 1'b0, 32'h0};
    tbl[7] = '{idle_s,                                                         4'h0, 2'd0, 32'h0,  4'b0001, 1'b0, 32'h0};
    tbl[8] = '{mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'd2, 2'd0, 32'h0),         4'h0, 2'd0, 32'h0,  4'b0000, 1'b1, 32'h0};

    reset = 1'b1; op_valid = 1'b0; op_cmd = 4'd0; op_data1 = 32'd0; op_data2 = 32'd0;
    out_response = 2'd0; out_tag = 2'd0; out_data = 32'd0;
    last_ready = 1'b0; last_tag = 2'd0;
    cyc = 0;
    model_clear();
    repeat (2) @(posedge c_clk);
    #1;

    // Reset values
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'h0);
    step(rst_s);

    // Add, response, NOP, invalid command
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].s);
      chk("tbl_cmd", 32'(req_cmd_in), 32'(tbl[i].e_cmd));
      chk("tbl_tag", 32'(req_tag_in), 32'(tbl[i].e_tag));
      chk("tbl_data", req_data_in, tbl[i].e_data);
      chk("tbl_busy", 32'(tags_busy), 32'(tbl[i].e_busy));
      chk("tbl_rv", 32'(rsp_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk("tbl_rdata", rsp_data, tbl[i].e_rdata);
    end
    chk("tbl_rresp", 32'(rsp_resp), 32'd2);

    // Tag exhaustion and reuse of a freed tag
    step(rst_s);
    for (int k = 0; k < 4; k++) begin
      step(mk(1'b0, 1'b1, 4'h2, 32'(k), 32'(k + 100), 2'd0, 2'd0, 32'd0));
      chk("exh_tag", 32'(last_tag), 32'(k));
      step(idle_s);
      step(idle_s);
    end
    chk("exh_busy", 32'(tags_busy), 32'hF);
    step(mk(1'b0, 1'b1, 4'h1, 32'h9, 32'h9, 2'd0, 2'd0, 32'd0));
    chk("exh_ready_low", 32'(last_ready), 32'd0);
    step(mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'd1, 2'd2, 32'h77));
    chk("exh_busy_freed", 32'(tags_busy), 32'hB);
    step(mk(1'b0, 1'b1, 4'h5, 32'h1, 32'h2, 2'd0, 2'd0, 32'd0));
    chk("exh_ready_high", 32'(last_ready), 32'd1);
    chk("exh_retag", 32'(last_tag), 32'd2);

    // Stray response is forwarded and sticky
    step(rst_s);
    step(mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'd2, 2'd3, 32'hDEAD));
    chk("stray_rv", 32'(rsp_valid), 32'd1);
    chk("stray_resp", 32'(rsp_resp), 32'd2);
    chk("stray_set", 32'(stray_rsp_err), 32'd1);
    step(mk(1'b0, 1'b1, 4'h1, 32'h4, 32'h4, 2'd0, 2'd0, 32'd0));
    step(idle_s);
    step(mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'd1, 2'd0, 32'h8));
    step(idle_s);
    chk("stray_hold", 32'(stray_rsp_err), 32'd1);

    // Timeout frees the tag exactly TIMEOUT edges after allocation
    step(rst_s);
    step(mk(1'b0, 1'b1, 4'h6, 32'h80, 32'h1, 2'd0, 2'd0, 32'd0));
    for (int k = 0; k < int'(TMO) - 1; k++) step(idle_s);
    chk("tmo_busy_before", 32'(tags_busy), 32'h1);
    chk("tmo_err_before", 32'(timeout_err), 32'd0);
    step(idle_s);
    chk("tmo_busy_after", 32'(tags_busy), 32'h0);
    chk("tmo_err_after", 32'(timeout_err), 32'd1);
    chk("tmo_no_stray", 32'(stray_rsp_err), 32'd0);
    step(mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'd1, 2'd0, 32'h40));
    chk("tmo_late_stray", 32'(stray_rsp_err), 32'd1);

    // Reset during the second request beat
    step(rst_s);
    step(mk(1'b0, 1'b1, 4'h1, 32'h12, 32'h34, 2'd0, 2'd0, 32'd0));
    step(idle_s);
    chk("mid_d2", req_data_in, 32'h34);
    step(rst_s);
    chk("mid_ready_in_rst", 32'(last_ready), 32'd0);
    chk("mid_pins", {req_cmd_in, req_tag_in, req_data_in[25:0]}, 32'h0);
    chk("mid_busy", 32'(tags_busy), 32'h0);
    step(idle_s);
    chk("mid_ready_after", 32'(last_ready), 32'd1);

    // Random traffic against the model
    step(rst_s);
    for (int n = 0; n < 3000; n++) begin
      stim_t s;
      logic [3:0] cmds [7];
      int t;
      cmds = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h6, 4'hF, 4'h3};
      s = idle_s;
      s.rst   = ($urandom_range(0, 299) == 0);
      s.valid = $urandom_range(0, 1) == 1;
      s.cmd   = cmds[$urandom_range(0, 6)];
      s.d1    = $urandom;
      s.d2    = $urandom;
      if (m_busy != 4'b0 && $urandom_range(0, 2) == 0) begin
        t = $urandom_range(0, 3);
        for (int j = 0; j < 4 && !m_busy[t]; j++) t = (t + 1) % 4;
        s.resp  = 2'($urandom_range(1, 3));
        s.rtag  = 2'(t);
        s.rdata = $urandom;
      end else if ($urandom_range(0, 39) == 0) begin
        s.resp  = 2'($urandom_range(1, 3));
        s.rtag  = 2'($urandom_range(0, 3));
        s.rdata = $urandom;
      end
      step(s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
